// File: rtl/bram_pkg.sv
// Shared definitions for the true dual-port byte-enable block RAM.
//   clog2            : address width helper, never returns less than 1
//   WM_*             : legal WRITE_MODE strings
//   MAX_READ_LATENCY : upper bound of the read pipeline length
//   merge_bytes      : replaces the byte lanes selected by be with new data
package bram_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int MAX_W            = 512;

    localparam string WM_READ_FIRST  = "READ_FIRST";
    localparam string WM_WRITE_FIRST = "WRITE_FIRST";

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Operates on MAX_W-wide vectors so one function serves every data
    // width; callers zero-extend the inputs and truncate the result.
    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0] old_d,
        input logic [MAX_W-1:0] new_d,
        input logic [MAX_W-1:0] be,
        input int               byte_w
    );
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = be[i / byte_w] ? new_d[i] : old_d[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data delay line: STAGES registers of {data, valid}.
//   clk_in, rst_in : clock and synchronous active-high clear
//   din, vin       : data/valid entering the line
//   dout, vout     : data/valid leaving the line
// Data only advances alongside a valid bit, so dout holds its last value
// while vout is low. STAGES = 0 is a straight wire.
module bram_rd_pipe #(
    parameter int W      = 32,
    parameter int STAGES = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] din,
    input  logic         vin,
    output logic [W-1:0] dout,
    output logic         vout
);

    if (STAGES == 0) begin : g_wire
        assign dout = din;
        assign vout = vin;
    end else begin : g_regs
        logic [STAGES-1:0][W-1:0] data_q, data_d;
        logic [STAGES-1:0]        valid_q, valid_d;

        always_comb begin
            data_d     = data_q;
            valid_d    = valid_q;
            valid_d[0] = vin;
            data_d[0]  = vin ? din : data_q[0];
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                data_q  <= '0;
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign dout = data_q[STAGES-1];
        assign vout = valid_q[STAGES-1];
    end

endmodule

// File: rtl/tdp_bram_be_pipe.sv
// True dual-port block RAM with per-byte write enables.
//   clk_in, rst_in            : clock, synchronous active-high reset
//   addrX, dinX, beX, enX     : port X request (be all-zero = pure read)
//   doutX, validX             : port X read data and one-cycle valid strobe
//   collision                 : pulse when both ports hit one address and
//                               at least one of them writes
// Every accepted request (reads and writes) returns data READ_LATENCY
// cycles later. Write collisions merge lane by lane with port A winning
// overlapping lanes; WRITE_FIRST reads see the merged value through local
// forwarding rather than relying on the inferred RAM's behaviour.
module tdp_bram_be_pipe
    import bram_pkg::*;
#(
    parameter int    RAM_WIDTH    = 32,
    parameter int    BYTE_W       = 8,
    parameter int    RAM_DEPTH    = 1024,
    parameter int    READ_LATENCY = 2,
    parameter string WRITE_MODE   = "READ_FIRST",
    parameter string INIT_FILE    = "",
    localparam int   NUM_BE       = RAM_WIDTH / BYTE_W,
    localparam int   ADDR_W       = clog2(RAM_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [NUM_BE-1:0]    bea,
    input  logic                 ena,
    output logic [RAM_WIDTH-1:0] douta,
    output logic                 valida,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic [NUM_BE-1:0]    beb,
    input  logic                 enb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 validb,
    output logic                 collision
);

    if (RAM_WIDTH % BYTE_W != 0) begin : g_err_width
        $error("RAM_WIDTH must be a multiple of BYTE_W");
    end
    if (RAM_WIDTH > MAX_W) begin : g_err_max_w
        $error("RAM_WIDTH exceeds bram_pkg::MAX_W");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_err_lat
        $error("READ_LATENCY must be within 1..4");
    end
    if (WRITE_MODE != WM_READ_FIRST && WRITE_MODE != WM_WRITE_FIRST) begin : g_err_mode
        $error("WRITE_MODE must be READ_FIRST or WRITE_FIRST");
    end

    localparam bit                WF      = (WRITE_MODE == WM_WRITE_FIRST);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(RAM_DEPTH);

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH] = '{default: '0};

    function automatic logic [RAM_WIDTH-1:0] merge_w(
        input logic [RAM_WIDTH-1:0] old_d,
        input logic [RAM_WIDTH-1:0] new_d,
        input logic [NUM_BE-1:0]    be
    );
        return RAM_WIDTH'(merge_bytes(MAX_W'(old_d), MAX_W'(new_d), MAX_W'(be), BYTE_W));
    endfunction

    logic                 acc_a, acc_b, inr_a, inr_b, same_addr;
    logic [NUM_BE-1:0]    wbe_a, wbe_b;
    logic [RAM_WIDTH-1:0] old_a, old_b, post_a, post_b, rd_a, rd_b;
    logic                 wr_a_en, wr_b_en, collision_d;
    logic [RAM_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic                 rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
    logic                 collision_q;

    always_comb begin
        acc_a     = ena & ~rst_in;
        acc_b     = enb & ~rst_in;
        inr_a     = {1'b0, addra} < DEPTH_L;
        inr_b     = {1'b0, addrb} < DEPTH_L;
        wbe_a     = (acc_a & inr_a) ? bea : '0;
        wbe_b     = (acc_b & inr_b) ? beb : '0;
        same_addr = acc_a & acc_b & (addra == addrb);
        old_a     = inr_a ? mem_q[addra] : '0;
        old_b     = inr_b ? mem_q[addrb] : '0;

        // B merges first and A last, so A owns any lane both ports write.
        post_a = merge_w(merge_w(old_a, dinb, same_addr ? wbe_b : '0), dina, wbe_a);
        post_b = merge_w(merge_w(old_b, dinb, wbe_b), dina, same_addr ? wbe_a : '0);
        rd_a   = WF ? post_a : old_a;
        rd_b   = WF ? post_b : old_b;

        // On a shared address port A stores the fully merged word alone.
        wr_a_en = |wbe_a;
        wr_b_en = (|wbe_b) & ~(same_addr & wr_a_en);

        collision_d  = same_addr & ((|bea) | (|beb));
        rd_valid_a_d = acc_a;
        rd_valid_b_d = acc_b;
        rd_data_a_d  = acc_a ? rd_a : rd_data_a_q;
        rd_data_b_d  = acc_b ? rd_b : rd_data_b_q;
    end

    always_ff @(posedge clk_in) begin
        if (wr_a_en) mem_q[addra] <= post_a;
        if (wr_b_en) mem_q[addrb] <= post_b;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            collision_q  <= collision_d;
        end
    end

    bram_rd_pipe #(.W(RAM_WIDTH), .STAGES(READ_LATENCY - 1)) u_pipe_a (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .din    (rd_data_a_q),
        .vin    (rd_valid_a_q),
        .dout   (douta),
        .vout   (valida)
    );

    bram_rd_pipe #(.W(RAM_WIDTH), .STAGES(READ_LATENCY - 1)) u_pipe_b (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .din    (rd_data_b_q),
        .vin    (rd_valid_b_q),
        .dout   (doutb),
        .vout   (validb)
    );

    assign collision = collision_q;

endmodule
